// File: rtl/float_log_prep_if.sv
// -----------------------------------------------------------------------------
// float_log_prep_if
// Stream bundle for float_log_prep: the input float handshake and the paired
// result handshake.
//   in_valid / in_ready / in_data         : input float x
//   out_valid / out_ready                 : paired result handshake
//   out_nln2 / out_y / out_flag           : n*ln2, y and class of the head result
// master : the side that feeds x and consumes results (testbench / upstream)
// slave  : float_log_prep itself
// -----------------------------------------------------------------------------
interface float_log_prep_if #(
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_nln2;
    logic [DATA_W-1:0] out_y;
    logic [2:0]        out_flag;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_nln2, out_y, out_flag
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_nln2, out_y, out_flag
    );
endinterface

// File: rtl/float_log_prep.sv
// -----------------------------------------------------------------------------
// float_log_prep
// Front end of the float log(x) datapath. Splits x = 1.m * 2^n into n*ln2 and
// y = (1 - 1.m) / (1 + 1.m) by driving external fixed2float, mult, add, sub and
// div cores, classifies special inputs, and re-pairs the mult and div results
// in order through show-ahead FIFOs onto one valid/ready output.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   bus (slave)           input float stream and paired result stream
//   err_clr               clears the sticky error bits
//   err_misalign          sticky: add_rdy and sub_rdy disagreed in some cycle
//   err_overflow          sticky: a FIFO push was attempted while full
//   fixed2float_*         integer n -> float n
//   mult_*                float n * ln2
//   add_* / sub_*         1 + 1.m and 1 - 1.m
//   div_*                 (1 - 1.m) / (1 + 1.m)
// -----------------------------------------------------------------------------

// Show-ahead FIFO with wrap-bit pointers. A push into a full FIFO is dropped
// and reported on o_overflow; the pointers are left untouched.
module float_log_prep_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic [W-1:0] o_head,
    output logic         o_empty,
    output logic         o_overflow
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] r_mem [DEPTH];
    logic [AW:0]  r_wr;
    logic [AW:0]  r_rd;
    logic         w_full;
    logic         w_empty;
    logic         w_do_push;
    logic         w_do_pop;

    assign w_empty    = (r_wr == r_rd);
    assign w_full     = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
    assign w_do_push  = i_push && !w_full;
    assign w_do_pop   = i_pop && !w_empty;
    assign o_overflow = i_push && w_full;
    assign o_empty    = w_empty;
    assign o_head     = r_mem[r_rd[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (w_do_push) r_wr <= r_wr + 1'b1;
            if (w_do_pop)  r_rd <= r_rd + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr[AW-1:0]] <= i_data;
    end
endmodule

module float_log_prep #(
    parameter int                     EXP_W      = 8,
    parameter int                     MAN_W      = 23,
    parameter int                     FIFO_DEPTH = 16,
    parameter logic [EXP_W+MAN_W:0]   LN2_CONST  = 32'h3F317218,
    parameter logic [EXP_W+MAN_W:0]   ONE_CONST  = 32'h3F800000
) (
    input  logic                   clk,
    input  logic                   reset,
    float_log_prep_if.slave        bus,
    input  logic                   err_clr,
    output logic                   err_misalign,
    output logic                   err_overflow,

    output logic [EXP_W+MAN_W:0]   fixed2float_a,
    output logic                   fixed2float_valid,
    input  logic [EXP_W+MAN_W:0]   fixed2float_result,
    input  logic                   fixed2float_rdy,

    output logic [EXP_W+MAN_W:0]   mult_a,
    output logic [EXP_W+MAN_W:0]   mult_b,
    output logic                   mult_valid,
    input  logic [EXP_W+MAN_W:0]   mult_result,
    input  logic                   mult_rdy,

    output logic [EXP_W+MAN_W:0]   add_a,
    output logic [EXP_W+MAN_W:0]   add_b,
    output logic                   add_valid,
    input  logic [EXP_W+MAN_W:0]   add_result,
    input  logic                   add_rdy,

    output logic [EXP_W+MAN_W:0]   sub_a,
    output logic [EXP_W+MAN_W:0]   sub_b,
    output logic                   sub_valid,
    input  logic [EXP_W+MAN_W:0]   sub_result,
    input  logic                   sub_rdy,

    output logic [EXP_W+MAN_W:0]   div_a,
    output logic [EXP_W+MAN_W:0]   div_b,
    output logic                   div_valid,
    input  logic [EXP_W+MAN_W:0]   div_result,
    input  logic                   div_rdy
);
    localparam int              DATA_W = 1 + EXP_W + MAN_W;
    localparam int              BIAS   = 2**(EXP_W-1) - 1;
    localparam logic [EXP_W:0]  BIAS_X = (EXP_W+1)'(BIAS);
    localparam int              CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FIFO_DEPTH);

    localparam logic [2:0] FLAG_NORMAL = 3'd0;
    localparam logic [2:0] FLAG_ZERO   = 3'd1;
    localparam logic [2:0] FLAG_NEG    = 3'd2;
    localparam logic [2:0] FLAG_PINF   = 3'd3;
    localparam logic [2:0] FLAG_NAN    = 3'd4;

    // ---------------------------------------------------------------- accept
    logic             w_acc;
    logic             w_out_hs;
    logic [CNT_W-1:0] r_outstanding;

    assign bus.in_ready = !reset && (r_outstanding < CNT_MAX);
    assign w_acc        = bus.in_valid && bus.in_ready;
    assign w_out_hs     = bus.out_valid && bus.out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_outstanding <= '0;
        end else if (w_acc && !w_out_hs) begin
            r_outstanding <= r_outstanding + 1'b1;
        end else if (!w_acc && w_out_hs) begin
            r_outstanding <= r_outstanding - 1'b1;
        end
    end

    // ------------------------------------------------------- field split
    logic                 w_s;
    logic [EXP_W-1:0]     w_e;
    logic [MAN_W-1:0]     w_m;
    logic                 w_e_ones;
    logic [EXP_W:0]       w_n_short;
    logic [DATA_W-1:0]    w_n;
    logic [DATA_W-1:0]    w_mant;
    logic [2:0]           w_flag;

    assign w_s       = bus.in_data[DATA_W-1];
    assign w_e       = bus.in_data[DATA_W-2:MAN_W];
    assign w_m       = bus.in_data[MAN_W-1:0];
    assign w_e_ones  = &w_e;
    // unbiased exponent in EXP_W+1 bits two's complement, then sign-extended
    assign w_n_short = {1'b0, w_e} - BIAS_X;
    assign w_n       = {{(DATA_W-EXP_W-1){w_n_short[EXP_W]}}, w_n_short};
    // 1.m as a positive float with a zero unbiased exponent
    assign w_mant    = {1'b0, BIAS_X[EXP_W-1:0], w_m};

    always_comb begin
        w_flag = FLAG_NORMAL;
        if (w_e_ones && (w_m != '0)) begin
            w_flag = FLAG_NAN;
        end else if (w_e_ones && !w_s) begin
            w_flag = FLAG_PINF;
        end else if (w_e_ones) begin
            w_flag = FLAG_NEG;
        end else if (w_e == '0) begin
            w_flag = FLAG_ZERO;
        end else if (w_s) begin
            w_flag = FLAG_NEG;
        end
    end

    // ------------------------------------------------------------ stage 1
    logic [DATA_W-1:0] r_n;
    logic [DATA_W-1:0] r_mant;
    logic              r_v1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_n    <= '0;
            r_mant <= '0;
            r_v1   <= 1'b0;
        end else begin
            r_v1 <= w_acc;
            if (w_acc) begin
                r_n    <= w_n;
                r_mant <= w_mant;
            end
        end
    end

    // --------------------------------------------------------- core drive
    // Special classes still flow through the cores so every input produces
    // exactly one mult and one div result and ordering is never broken.
    assign fixed2float_a     = r_n;
    assign fixed2float_valid = r_v1;

    assign mult_a     = fixed2float_result;
    assign mult_b     = LN2_CONST;
    assign mult_valid = fixed2float_rdy && !reset;

    assign add_a     = ONE_CONST;
    assign add_b     = r_mant;
    assign add_valid = r_v1;
    assign sub_a     = ONE_CONST;
    assign sub_b     = r_mant;
    assign sub_valid = r_v1;

    assign div_a     = sub_result;
    assign div_b     = add_result;
    assign div_valid = sub_rdy && add_rdy && !reset;

    // ---------------------------------------------------------- re-pairing
    logic [DATA_W-1:0] w_head_n;
    logic [DATA_W-1:0] w_head_y;
    logic [2:0]        w_head_f;
    logic              w_empty_n;
    logic              w_empty_y;
    logic              w_empty_f;
    logic              w_ovf_n;
    logic              w_ovf_y;
    logic              w_ovf_f;

    float_log_prep_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo_n (
        .clk        (clk),
        .reset      (reset),
        .i_push     (mult_rdy),
        .i_data     (mult_result),
        .i_pop      (w_out_hs),
        .o_head     (w_head_n),
        .o_empty    (w_empty_n),
        .o_overflow (w_ovf_n)
    );

    float_log_prep_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo_y (
        .clk        (clk),
        .reset      (reset),
        .i_push     (div_rdy),
        .i_data     (div_result),
        .i_pop      (w_out_hs),
        .o_head     (w_head_y),
        .o_empty    (w_empty_y),
        .o_overflow (w_ovf_y)
    );

    float_log_prep_fifo #(.W(3), .DEPTH(FIFO_DEPTH)) u_fifo_f (
        .clk        (clk),
        .reset      (reset),
        .i_push     (w_acc),
        .i_data     (w_flag),
        .i_pop      (w_out_hs),
        .o_head     (w_head_f),
        .o_empty    (w_empty_f),
        .o_overflow (w_ovf_f)
    );

    // Heads are gated by out_valid so nothing stale leaks out of an empty FIFO,
    // and zeroed for special classes.
    logic w_normal;

    assign bus.out_valid = !w_empty_n && !w_empty_y && !w_empty_f;
    assign w_normal      = bus.out_valid && (w_head_f == FLAG_NORMAL);
    assign bus.out_flag  = bus.out_valid ? w_head_f : 3'd0;
    assign bus.out_nln2  = w_normal ? w_head_n : '0;
    assign bus.out_y     = w_normal ? w_head_y : '0;

    // -------------------------------------------------------------- errors
    logic w_misalign;
    logic w_overflow;
    logic r_err_misalign;
    logic r_err_overflow;

    assign w_misalign = (add_rdy != sub_rdy);
    assign w_overflow = w_ovf_n || w_ovf_y || w_ovf_f;

    // a set event in the same cycle as err_clr keeps the bit set
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err_misalign <= 1'b0;
            r_err_overflow <= 1'b0;
        end else begin
            if (w_misalign)   r_err_misalign <= 1'b1;
            else if (err_clr) r_err_misalign <= 1'b0;
            if (w_overflow)   r_err_overflow <= 1'b1;
            else if (err_clr) r_err_overflow <= 1'b0;
        end
    end

    assign err_misalign = r_err_misalign;
    assign err_overflow = r_err_overflow;
endmodule

// File: tb/tb_float_log_prep.sv
module tb_float_log_prep;
    logic clk;
    logic reset;
    logic err_clr;
    logic err_misalign, err_overflow;
    logic [31:0] fixed2float_a, fixed2float_result;
    logic        fixed2float_valid, fixed2float_rdy;
    logic [31:0] mult_a, mult_b, mult_result;
    logic        mult_valid, mult_rdy;
    logic [31:0] add_a, add_b, add_result;
    logic        add_valid, add_rdy;
    logic [31:0] sub_a, sub_b, sub_result;
    logic        sub_valid, sub_rdy;
    logic [31:0] div_a, div_b, div_result;
    logic        div_valid, div_rdy;
    logic        misalign_mode;

    int tests;
    int fails;

    float_log_prep_if #(.DATA_W(32)) bus ();

    float_log_prep dut (
        .clk(clk), .reset(reset), .bus(bus), .err_clr(err_clr),
        .err_misalign(err_misalign), .err_overflow(err_overflow),
        .fixed2float_a(fixed2float_a), .fixed2float_valid(fixed2float_valid),
        .fixed2float_result(fixed2float_result), .fixed2float_rdy(fixed2float_rdy),
        .mult_a(mult_a), .mult_b(mult_b), .mult_valid(mult_valid),
        .mult_result(mult_result), .mult_rdy(mult_rdy),
        .add_a(add_a), .add_b(add_b), .add_valid(add_valid),
        .add_result(add_result), .add_rdy(add_rdy),
        .sub_a(sub_a), .sub_b(sub_b), .sub_valid(sub_valid),
        .sub_result(sub_result), .sub_rdy(sub_rdy),
        .div_a(div_a), .div_b(div_b), .div_valid(div_valid),
        .div_result(div_result), .div_rdy(div_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------------------------------------------- float helpers
    function automatic real f2r(input logic [31:0] b);
        real v;
        int  e;
        if (b[30:23] == 8'd0 || b[30:23] == 8'hFF) return 0.0;
        v = 1.0 + $itor(b[22:0]) / 8388608.0;
        e = int'(b[30:23]) - 127;
        while (e > 0) begin v = v * 2.0; e--; end
        while (e < 0) begin v = v / 2.0; e++; end
        return b[31] ? -v : v;
    endfunction

    function automatic logic [31:0] r2f(input real v);
        real a;
        int  e;
        int  fi;
        int  guard;
        logic s;
        logic [7:0] eb;
        logic [22:0] mb;
        if (v == 0.0) return 32'h0;
        s = (v < 0.0);
        a = s ? -v : v;
        e = 127;
        guard = 0;
        while (a >= 2.0 && guard < 300) begin a = a / 2.0; e++; guard++; end
        while (a < 1.0 && guard < 300) begin a = a * 2.0; e--; guard++; end
        fi = $rtoi((a - 1.0) * 8388608.0 + 0.5);
        if (fi >= 8388608) begin fi = 0; e++; end
        eb = e[7:0];
        mb = fi[22:0];
        return {s, eb, mb};
    endfunction

    // ------------------------------------------------------- core models
    logic [31:0] f2f_d [6];  logic f2f_v [6];
    logic [31:0] mul_d [8];  logic mul_v [8];
    logic [31:0] add_d [12]; logic add_v [12];
    logic [31:0] sub_d [11]; logic sub_v [11];
    logic [31:0] dv_d  [28]; logic dv_v  [28];

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 6; i++)  f2f_v[i] <= 1'b0;
            for (int i = 0; i < 8; i++)  mul_v[i] <= 1'b0;
            for (int i = 0; i < 12; i++) add_v[i] <= 1'b0;
            for (int i = 0; i < 11; i++) sub_v[i] <= 1'b0;
            for (int i = 0; i < 28; i++) dv_v[i]  <= 1'b0;
        end else begin
            f2f_v[0] <= fixed2float_valid;
            f2f_d[0] <= fixed2float_valid ? r2f($itor($signed(fixed2float_a))) : 32'h0;
            mul_v[0] <= mult_valid;
            mul_d[0] <= mult_valid ? r2f(f2r(mult_a) * f2r(mult_b)) : 32'h0;
            add_v[0] <= add_valid;
            add_d[0] <= add_valid ? r2f(f2r(add_a) + f2r(add_b)) : 32'h0;
            sub_v[0] <= sub_valid;
            sub_d[0] <= sub_valid ? r2f(f2r(sub_a) - f2r(sub_b)) : 32'h0;
            dv_v[0]  <= div_valid;
            dv_d[0]  <= (div_valid && f2r(div_b) != 0.0) ? r2f(f2r(div_a) / f2r(div_b)) : 32'h0;
            for (int i = 1; i < 6; i++)  begin f2f_v[i] <= f2f_v[i-1]; f2f_d[i] <= f2f_d[i-1]; end
            for (int i = 1; i < 8; i++)  begin mul_v[i] <= mul_v[i-1]; mul_d[i] <= mul_d[i-1]; end
            for (int i = 1; i < 12; i++) begin add_v[i] <= add_v[i-1]; add_d[i] <= add_d[i-1]; end
            for (int i = 1; i < 11; i++) begin sub_v[i] <= sub_v[i-1]; sub_d[i] <= sub_d[i-1]; end
            for (int i = 1; i < 28; i++) begin dv_v[i]  <= dv_v[i-1];  dv_d[i]  <= dv_d[i-1];  end
        end
    end

    assign fixed2float_rdy    = f2f_v[5];
    assign fixed2float_result = f2f_d[5];
    assign mult_rdy           = mul_v[7];
    assign mult_result        = mul_d[7];
    assign sub_rdy            = sub_v[10];
    assign sub_result         = sub_d[10];
    assign add_rdy            = misalign_mode ? add_v[11] : add_v[10];
    assign add_result         = misalign_mode ? add_d[11] : add_d[10];
    assign div_rdy            = dv_v[27];
    assign div_result         = dv_d[27];

    // --------------------------------------------------------- scoreboard
    typedef struct packed {
        logic [31:0] n;
        logic [31:0] y;
        logic [2:0]  f;
    } res_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
    } core_t;

    res_t  exp_q [$];
    core_t core_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL out_unexpected: got flag %0d expected no result", bus.out_flag);
            end else begin
                res_t r;
                r = exp_q.pop_front();
                check("out_flag", {29'd0, bus.out_flag}, {29'd0, r.f});
                check("out_nln2", bus.out_nln2, r.n);
                check("out_y", bus.out_y, r.y);
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && fixed2float_valid) begin
            if (core_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL core_unexpected: got issue a=%08h expected none", fixed2float_a);
            end else begin
                core_t c;
                c = core_q.pop_front();
                check("fixed2float_a", fixed2float_a, c.a);
                check("sub_b", sub_b, c.b);
            end
        end
    end

    // --------------------------------------------------------- stimulus
    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [31:0] x, input logic [31:0] en, input logic [31:0] ey,
                        input logic [2:0] ef, input logic [31:0] ea, input logic [31:0] eb);
        bit ok;
        res_t r;
        core_t c;
        ok = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = x;
        for (int k = 0; k < 500 && !ok; k++) begin
            @(negedge clk);
            if (bus.in_ready) ok = 1;
            else begin @(posedge clk); #1; end
        end
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: got in_ready 0 expected 1 for x=%08h", x);
        end else begin
            r = '{n: en, y: ey, f: ef};
            c = '{a: ea, b: eb};
            exp_q.push_back(r);
            core_q.push_back(c);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        bit done;
        done = 0;
        for (int k = 0; k < 2000 && !done; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0) done = 1;
        end
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        exp_q.delete();
        core_q.delete();
        repeat (40) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    logic [31:0] vx [3];
    logic [31:0] vn [3];
    logic [31:0] vy [3];
    logic [31:0] va [3];
    logic [31:0] vb [3];

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int accepted;
        bit seen;
        tests = 0;
        fails = 0;
        misalign_mode = 1'b0;
        reset = 1'b1;
        err_clr = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = 32'h0;
        bus.out_ready = 1'b1;

        vx[0] = 32'h41000000; vn[0] = 32'h40051592; vy[0] = 32'h00000000; va[0] = 32'd3; vb[0] = 32'h3F800000;
        vx[1] = 32'h40400000; vn[1] = 32'h3F317218; vy[1] = 32'hBE4CCCCD; va[1] = 32'd1; vb[1] = 32'h3FC00000;
        vx[2] = 32'h3F800000; vn[2] = 32'h00000000; vy[2] = 32'h00000000; va[2] = 32'd0; vb[2] = 32'h3F800000;

        repeat (5) @(negedge clk);
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_out_nln2", bus.out_nln2, 32'd0);
        check("rst_out_y", bus.out_y, 32'd0);
        check("rst_out_flag", {29'd0, bus.out_flag}, 32'd0);
        check("rst_errs", {30'd0, err_misalign, err_overflow}, 32'd0);
        check("rst_core_valids", {27'd0, fixed2float_valid, mult_valid, add_valid, sub_valid, div_valid}, 32'd0);
        repeat (35) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk); #1;

        // basic vectors
        send(32'h3F800000, 32'h00000000, 32'h00000000, 3'd0, 32'd0, 32'h3F800000);
        send(32'h41000000, 32'h40051592, 32'h00000000, 3'd0, 32'd3, 32'h3F800000);
        send(32'h40400000, 32'h3F317218, 32'hBE4CCCCD, 3'd0, 32'd1, 32'h3FC00000);
        wait_drain();

        // special classes back-to-back
        send(32'h3F800000, 32'h0, 32'h0, 3'd0, 32'd0,         32'h3F800000);
        send(32'hC0000000, 32'h0, 32'h0, 3'd2, 32'd1,         32'h3F800000);
        send(32'h00000000, 32'h0, 32'h0, 3'd1, 32'hFFFFFF81,  32'h3F800000);
        send(32'h7F800000, 32'h0, 32'h0, 3'd3, 32'd128,       32'h3F800000);
        send(32'h7FC00000, 32'h0, 32'h0, 3'd4, 32'd128,       32'h3FC00000);
        wait_drain();

        // backpressure: 20 offered, 16 accepted
        bus.out_ready = 1'b0;
        accepted = 0;
        for (int i = 0; i < 20; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = vx[i % 3];
            @(negedge clk);
            if (bus.in_ready) begin
                res_t r;
                core_t c;
                r = '{n: vn[i % 3], y: vy[i % 3], f: 3'd0};
                c = '{a: va[i % 3], b: vb[i % 3]};
                exp_q.push_back(r);
                core_q.push_back(c);
                accepted++;
            end
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        check("flood_accepted", accepted, 32'd16);
        repeat (80) @(posedge clk);
        @(negedge clk);
        check("flood_in_ready", {31'd0, bus.in_ready}, 32'd0);
        check("flood_out_valid", {31'd0, bus.out_valid}, 32'd1);
        check("hold_nln2_a", bus.out_nln2, 32'h40051592);
        repeat (3) @(negedge clk);
        check("hold_nln2_b", bus.out_nln2, 32'h40051592);
        check("hold_flag_b", {29'd0, bus.out_flag}, 32'd0);
        check("flood_overflow", {31'd0, err_overflow}, 32'd0);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        wait_drain();
        @(negedge clk);
        check("drain_in_ready", {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk); #1;

        // reset mid-stream with results pending
        bus.out_ready = 1'b0;
        for (int i = 0; i < 16; i++)
            send(vx[i % 3], vn[i % 3], vy[i % 3], 3'd0, va[i % 3], vb[i % 3]);
        repeat (80) @(posedge clk);
        @(negedge clk);
        check("pre_rst_out_valid", {31'd0, bus.out_valid}, 32'd1);
        check("pre_rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        exp_q.delete();
        core_q.delete();
        @(negedge clk);
        check("mid_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        repeat (40) @(posedge clk);
        #1;
        reset = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("after_mid_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("after_mid_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        @(posedge clk); #1;

        // add_rdy one cycle late
        misalign_mode = 1'b1;
        send(32'h3F800000, 32'h0, 32'h0, 3'd0, 32'd0, 32'h3F800000);
        seen = 0;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge clk);
            if (err_misalign) seen = 1;
        end
        check("misalign_set", {31'd0, err_misalign}, 32'd1);
        repeat (25) @(negedge clk);
        check("misalign_sticky", {31'd0, err_misalign}, 32'd1);
        @(posedge clk); #1;
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        @(negedge clk);
        check("misalign_clr", {31'd0, err_misalign}, 32'd0);
        misalign_mode = 1'b0;
        do_reset();

        // recovery
        send(32'h40400000, 32'h3F317218, 32'hBE4CCCCD, 3'd0, 32'd1, 32'h3FC00000);
        wait_drain();
        @(negedge clk);
        check("final_errs", {30'd0, err_misalign, err_overflow}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/float_log_prep.md
Name: float_log_prep

Overview:
Front end of the floating-point log(x) datapath for histogram equalisation. It splits IEEE-style float x = 1.m*2^n into two terms: n*ln2, and y = (1-1.m)/(1+1.m). It drives the team's external fixed2float, mult, add, sub and div cores and classifies special inputs. Because the mult and div paths have different latencies, it re-pairs their results in order through internal FIFOs and presents them on a single valid/ready output. It is the parametrised successor of the single-precision separator: any exponent/mantissa width, with backpressure, special-value handling and error monitoring.

Parameters:
EXP_W, 8, exponent field width; BIAS = 2^(EXP_W-1)-1 (localparam).
MAN_W, 23, mantissa field width; DATA_W = 1+EXP_W+MAN_W (localparam).
FIFO_DEPTH, 16, entries per re-pairing FIFO; also the in-flight limit; power of 2, >=4.
LN2_CONST, 32'h3F317218, ln2 in the target float format (DATA_W bits).
ONE_CONST, 32'h3F800000, 1.0 in the target float format (DATA_W bits).

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
in_valid  in  1  input float valid
in_ready  out  1  block can accept an input
in_data  in  DATA_W  input float x
out_valid  out  1  paired result available
out_ready  in  1  downstream accepts the result
out_nln2  out  DATA_W  n*ln2
out_y  out  DATA_W  y
out_flag  out  3  class: 0 normal, 1 zero/denormal, 2 negative, 3 +inf, 4 NaN
err_clr  in  1  clears the sticky error bits
err_misalign  out  1  sticky: add_rdy != sub_rdy was seen in some cycle
err_overflow  out  1  sticky: a result FIFO or the flag FIFO was written while full
fixed2float_a / _valid  out  DATA_W / 1 ; fixed2float_result / _rdy  in  DATA_W / 1
mult_a, mult_b / mult_valid  out  DATA_W / 1 ; mult_result / mult_rdy  in  DATA_W / 1
add_a, add_b / add_valid  out  DATA_W / 1 ; add_result / add_rdy  in
sub_a, sub_b / sub_valid  out ; sub_result / sub_rdy  in
div_a, div_b / div_valid  out ; div_result / div_rdy  in

Behaviour:
- Accept: acc = in_valid & in_ready. The counter outstanding (0..FIFO_DEPTH) increments on acc and decrements on the output handshake (out_valid & out_ready); both in one cycle leaves it unchanged. in_ready = (outstanding < FIFO_DEPTH).
- Stage 1 (registered, one cycle after acc):
  - n = {1'b0,e} - BIAS, sign-extended to DATA_W.
  - mant = {1'b0, BIAS[EXP_W-1:0], m}. The sign is cleared.
  - v1 = acc.
  - The class is written to the flag FIFO in the same cycle.
- Classification, in priority order:
  - e = all ones and m != 0 -> NaN.
  - e = all ones and sign = 0 -> +inf.
  - e = all ones and sign = 1 -> negative.
  - e = 0 -> zero/denormal.
  - sign = 1 -> negative.
  - otherwise -> normal.
- Core drive (combinational from stage 1 / core outputs):
  - fixed2float_a = n, fixed2float_valid = v1.
  - mult_a = fixed2float_result, mult_b = LN2_CONST, mult_valid = fixed2float_rdy.
  - sub_a = add_a = ONE_CONST, sub_b = add_b = mant, sub_valid = add_valid = v1.
  - div_a = sub_result, div_b = add_result, div_valid = sub_rdy & add_rdy.
- Special classes are still issued to the cores, so result ordering is preserved.
- Re-pairing:
  - mult_rdy pushes mult_result into FIFO_N.
  - div_rdy pushes div_result into FIFO_Y.
  - All three FIFOs are show-ahead; a push is visible at the head the next cycle.
  - out_valid = !empty(FIFO_N) & !empty(FIFO_Y) & !empty(FIFO_F).
  - On out_valid & out_ready, all three FIFOs pop together.
  - Data outputs = FIFO heads. When head flag != 0, out_nln2 = out_y = 0.
  - Output must stay stable while out_valid & !out_ready.
- Latency: out_valid rises one cycle after the later of the matching mult_rdy / div_rdy pulses.
- Errors:
  - err_misalign sets in any cycle where add_rdy != sub_rdy.
  - err_overflow sets on a push into a full FIFO. The push is dropped; pointers stay unchanged.
  - Both bits clear on err_clr. If a set event and err_clr occur in the same cycle, set wins.
- Wrap-around: FIFO pointers are log2(FIFO_DEPTH)+1 bits and wrap freely; full/empty are decided by comparing the MSB and the remaining bits.
- Reset values:
  - Outputs: in_ready = 0 while reset is high, then 1. out_valid = 0, out_nln2 = 0, out_y = 0, out_flag = 0, err_* = 0, all core *_valid = 0.
  - Internal: outstanding and all FIFO pointers = 0.
- Reset mid-operation flushes everything. Core results arriving after reset is released are dropped only via err_overflow protection; the bench must hold reset >= the longest core latency.

Test Plan:
Bench core latencies are fixed2float 6, mult 8, add/sub 11, div 28.
- x = 0x3F800000 (1.0) -> fixed2float_a = 0, sub_b = 0x3F800000; out_nln2 = 0x00000000, out_y = 0x00000000, out_flag = 0.
- x = 0x41000000 (8.0) -> fixed2float_a = 3, sub_b = 0x3F800000; out_nln2 = 0x40051592 (3*ln2 +/-1 ulp), out_y = 0, out_flag = 0.
- x = 0x40400000 (3.0) -> fixed2float_a = 1, sub_b = 0x3FC00000, sub_result = 0xBF000000, add_result = 0x40200000; out_y = 0xBE4CCCCD (-0.2), out_nln2 = 0x3F317218.
- Stream 1.0, -2.0 (0xC0000000), 0x00000000, 0x7F800000, 0x7FC00000 back-to-back -> out_flag = 0,2,1,3,4 in order; outputs for flags 1-4 are all zeros.
- out_ready = 0, 20 inputs offered with FIFO_DEPTH = 16 -> exactly 16 accepted, in_ready = 0 afterwards, err_overflow = 0; then out_ready = 1 -> 16 results drain in order and in_ready returns to 1.
- add_rdy model delayed 1 cycle vs sub_rdy -> err_misalign = 1 and stays set; err_clr pulse -> 0. Asserting reset mid-stream -> out_valid = 0 and outstanding = 0 in the next cycle.
